seg_scan_reader: RTL
====================

Name: seg_scan_reader

Overview:
- Reader end of the active-low 7-segment display interface.
- Samples a time-multiplexed display bus (one-hot digit strobes plus shared active-low a..g segment lines), waits for each pattern to be stable, decodes it back to BCD and holds one register per digit.
- Used for loopback self-test of display drivers and for capturing external scanned displays.

Parameters:
- NUM_DIGITS, 4, number of digit strobes and stored digits (1..8).
- STABLE_CYCLES, 3, consecutive identical synchronized samples required before capture (2..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  [0:6]  segment lines, active-low; seg_in[0]=a … seg_in[6]=g.
- dig_en  input  NUM_DIGITS  digit strobes, active-high; one-hot while a digit is driven, all-zero between digits.
- bcd_out  output  4*NUM_DIGITS  decoded digits; digit i in bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  digit i has held a valid capture since reset.
- invalid_pat  output  NUM_DIGITS  last capture for digit i was an undefined pattern.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- multi_err  output  1  one-cycle pulse on entry into a multi-hot dig_en condition.

Behaviour:
- Reset: clk and rst only; rst asynchronous, active-high, and clears all state when asserted. During reset:
  - bcd_out = 0, digit_valid = 0, invalid_pat = 0, frame_done = 0, multi_err = 0.
  - Synchronizers, counter, capture mask and FSM are cleared; FSM goes to IDLE.
- Input synchronization: seg_in and dig_en pass through a 2-flop synchronizer. All decisions use the synchronized pair (S, D).
- Stability counter: counts consecutive cycles with (S, D) equal to the previous cycle's value. Any change resets it to 1.
- FSM states:
  - IDLE: D all-zero. Go to TRACK when D is one-hot. Go to MULTI when D is multi-hot.
  - TRACK: D one-hot, counting. Go to CAPTURE when the count reaches STABLE_CYCLES. Any change in D or S stays in TRACK with the count restarted. D=0 goes to IDLE; multi-hot goes to MULTI.
  - CAPTURE: one cycle; writes digit idx(D), then goes to HOLD.
  - HOLD: no further writes while (S, D) is unchanged. A change goes to TRACK, IDLE or MULTI per the rules above.
  - MULTI: multi_err pulses on the entry cycle only; no writes. Leave when D is zero or one-hot.
- Decode table (S as a..g, active-low):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111111 (blank)→4'hF, treated as valid.
- Capture of a valid pattern: bcd_out[i] is updated, digit_valid[i] is set to 1 and invalid_pat[i] is cleared.
- Capture of any other pattern: bcd_out[i] is retained, invalid_pat[i] is set to 1 and digit_valid[i] is unchanged.
- Latency: a pattern applied at the pins and held appears on bcd_out at rising edge 2+STABLE_CYCLES+1 after application (edge 6 for the default).
- Capture mask: NUM_DIGITS bits, set on every CAPTURE, valid or invalid.
  - When the mask is all ones, frame_done pulses on the next cycle and the mask clears in the same cycle.
  - A capture coinciding with the clear is kept in the new mask.
- Repeated captures of one digit within a frame are allowed; the last capture wins.
- Counter saturates at STABLE_CYCLES; no wrap-around.
- Reset mid-TRACK: no partial capture; previously stored digits are lost (cleared).

Optional Feature:
- Macro: SEG_SCAN_DP_EN.
- Defined:
  - Adds input dp_in (1, active-low decimal point) and output dp_out (NUM_DIGITS).
  - dp_in is synchronized and included in the stability comparison.
  - On any capture, dp_out[i] = ~dp_in(sync); reset value 0.
- Undefined: no dp ports; DP logic absent; behaviour otherwise identical.

Test Plan:
- Reset: assert rst for 3 cycles mid-traffic → all outputs 0 immediately (asynchronous); no frame_done or multi_err for 10 cycles after release with dig_en=0.
- Single capture: dig_en=0001, seg_in=0010010 held 8 cycles → bcd_out[3:0]=2 and digit_valid[0]=1 at edge 6, no earlier; no second write while held.
- Glitch rejection: dig_en=0010, seg_in=0000110 for 2 synced cycles, then 1001100 held → digit 1 becomes 4 (never 3), 3 cycles after the 1001100 sample.
- Invalid pattern: after digit 0=2, apply dig_en=0001, seg_in=1111110 held → invalid_pat[0]=1, bcd_out[3:0] stays 2; then 0000001 → bcd 0, invalid_pat[0]=0.
- Full scan: digits 0..3 = 1, 2, 3, blank, each strobed 6 cycles with 2 blank cycles between → bcd_out=16'hF321, exactly one frame_done pulse after the digit-3 capture.
- Multi-hot: dig_en=0011, seg_in=0000000 held 10 cycles → one multi_err pulse, bcd_out unchanged, no frame_done.

Source files
------------

// File: rtl/seg_scan_reader.sv
// Reader for a scanned active-low 7-segment bus: synchronizes, debounces, decodes to BCD per digit.
// Optional macro SEG_SCAN_DP_EN adds decimal-point capture (dp_in / dp_out).
module seg_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   invalid_pat,
  output logic                    frame_done,
  output logic                    multi_err
`ifdef SEG_SCAN_DP_EN
  ,
  input  logic                    dp_in,
  output logic [NUM_DIGITS-1:0]   dp_out
`endif
);

  localparam int CW = 4;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

  // state   | meaning
  // IDLE    | no digit strobed
  // TRACK   | one digit strobed, waiting for a stable pattern
  // CAPTURE | write the stable pattern into its digit register
  // HOLD    | pattern already captured, waiting for a change
  // MULTI   | more than one strobe active, writes blocked
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRACK   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_MULTI   = 3'd4;

  logic [0:6]              seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   dig_s1_q, dig_s2_q, dig_prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              state_q, state_d, route_st;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   valid_q, inv_q;
  logic                    frame_q, multi_q;
  logic                    changed, d_zero, d_onehot, d_multi, mask_full, cap_en;
  logic [4:0]              dec;

`ifdef SEG_SCAN_DP_EN
  logic                    dp_s1_q, dp_s2_q, dp_prev_q;
  logic [NUM_DIGITS-1:0]   dp_q;
`endif

  function automatic logic [4:0] decode_seg(input logic [0:6] s);
    case (s)
      7'b0000001: decode_seg = {1'b1, 4'h0};
      7'b1001111: decode_seg = {1'b1, 4'h1};
      7'b0010010: decode_seg = {1'b1, 4'h2};
      7'b0000110: decode_seg = {1'b1, 4'h3};
      7'b1001100: decode_seg = {1'b1, 4'h4};
      7'b0100100: decode_seg = {1'b1, 4'h5};
      7'b0100000: decode_seg = {1'b1, 4'h6};
      7'b0001111: decode_seg = {1'b1, 4'h7};
      7'b0000000: decode_seg = {1'b1, 4'h8};
      7'b0000100: decode_seg = {1'b1, 4'h9};
      7'b1111111: decode_seg = {1'b1, 4'hF};
      default:    decode_seg = {1'b0, 4'h0};
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      seg_prev_q <= '0;
      dig_s1_q   <= '0;
      dig_s2_q   <= '0;
      dig_prev_q <= '0;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      dig_s1_q   <= dig_en;
      dig_s2_q   <= dig_s1_q;
      dig_prev_q <= dig_s2_q;
    end
  end

`ifdef SEG_SCAN_DP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1_q   <= 1'b0;
      dp_s2_q   <= 1'b0;
      dp_prev_q <= 1'b0;
    end else begin
      dp_s1_q   <= dp_in;
      dp_s2_q   <= dp_s1_q;
      dp_prev_q <= dp_s2_q;
    end
  end

  assign changed = (seg_s2_q != seg_prev_q) || (dig_s2_q != dig_prev_q) || (dp_s2_q != dp_prev_q);
`else
  assign changed = (seg_s2_q != seg_prev_q) || (dig_s2_q != dig_prev_q);
`endif

  assign d_zero   = (dig_s2_q == '0);
  assign d_onehot = $onehot(dig_s2_q);
  assign d_multi  = !d_zero && !d_onehot;

  always_comb begin
    if (changed)
      cnt_d = CW'(1);
    else if (cnt_q >= STABLE_C)
      cnt_d = STABLE_C;
    else
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    if (d_zero)
      route_st = ST_IDLE;
    else if (d_multi)
      route_st = ST_MULTI;
    else
      route_st = ST_TRACK;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!d_zero)
          state_d = route_st;
      end
      ST_TRACK: begin
        if (d_onehot && cnt_d >= STABLE_C)
          state_d = ST_CAPTURE;
        else
          state_d = route_st;
      end
      ST_CAPTURE: begin
        state_d = changed ? route_st : ST_HOLD;
      end
      ST_HOLD: begin
        if (changed)
          state_d = route_st;
      end
      ST_MULTI: begin
        if (!d_multi)
          state_d = route_st;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The previous-sample registers hold exactly the pattern that was judged stable.
  assign cap_en    = (state_q == ST_CAPTURE);
  assign dec       = decode_seg(seg_prev_q);
  assign mask_full = &mask_q;
  assign mask_d    = (mask_full ? '0 : mask_q) | (cap_en ? dig_prev_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      frame_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      frame_q <= mask_full;
      multi_q <= (state_d == ST_MULTI) && (state_q != ST_MULTI);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q   <= '0;
      valid_q <= '0;
      inv_q   <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_prev_q[i]) begin
          if (dec[4]) begin
            bcd_q[4*i +: 4] <= dec[3:0];
            valid_q[i]      <= 1'b1;
            inv_q[i]        <= 1'b0;
          end else begin
            inv_q[i]        <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SEG_SCAN_DP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_prev_q[i])
          dp_q[i] <= ~dp_prev_q;
      end
    end
  end

  assign dp_out = dp_q;
`endif

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign invalid_pat = inv_q;
  assign frame_done  = frame_q;
  assign multi_err   = multi_q;

endmodule
